shift_exec_stage: RTL and testbench

Multi-cycle shift execution stage of the calc3 shifter pipe. Accepts dispatched shift commands through a 2-entry input buffer and computes a 64-bit shift result at up to 4 bit positions per cycle. Presents one single-cycle result beat per command to the shifter output stage, which samples it on the falling edge of `c_clk`.

---
 rtl/shift_exec_stage.sv | 180 ++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Multi-cycle 64-bit shift execution stage with a 2-entry in-order command buffer.
// Shifts up to 4 bit positions per cycle and emits one registered result beat per command.
module shift_exec_stage (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [0:3]  in_cmd,
    input  logic [0:3]  in_tag,
    input  logic [0:31] in_data1,
    input  logic [0:31] in_data2,
    input  logic [0:4]  in_result_reg,
    input  logic [0:4]  in_follow_branch,
    output logic [0:3]  shift_out_cmd,
    output logic [0:3]  shift_tag,
    output logic [0:63] shift_result,
    output logic [0:4]  shift_result_reg,
    output logic [0:4]  shift_follow_branch,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;

    // Buffer storage (data only; pointers and count carry the reset)
    logic [0:3]  f_cmd  [2];
    logic [0:3]  f_tag  [2];
    logic [0:31] f_d1   [2];
    logic [0:4]  f_amt  [2];
    logic [0:4]  f_reg  [2];
    logic [0:4]  f_fb   [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;

    logic        full, empty, push, pop;

    logic [0:63] w_q, w_d;
    logic [4:0]  rem_q, rem_d;
    logic        sll_q, sll_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:3]  tag_q, tag_d;
    logic [0:4]  reg_q, reg_d;
    logic [0:4]  fb_q, fb_d;
    logic        done_d;

    logic [0:3]  out_cmd_q;
    logic [0:3]  out_tag_q;
    logic [0:63] out_res_q;
    logic [0:4]  out_reg_q;
    logic [0:4]  out_fb_q;

    logic        head_valid, head_sll;
    logic [4:0]  head_amt, step;

    assign full   = (count_q == 2'd2);
    assign empty  = (count_q == 2'd0);
    assign in_rdy = !full && !reset;
    assign push   = in_vld && in_rdy;
    assign pop    = (state_q == StIdle) && !empty;
    assign busy   = (state_q != StIdle) || !empty;

    always_ff @(posedge c_clk) begin
        if (push) begin
            f_cmd[wr_ptr_q] <= in_cmd;
            f_tag[wr_ptr_q] <= in_tag;
            f_d1[wr_ptr_q]  <= in_data1;
            f_amt[wr_ptr_q] <= in_data2[27:31];
            f_reg[wr_ptr_q] <= in_result_reg;
            f_fb[wr_ptr_q]  <= in_follow_branch;
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_valid = (f_cmd[rd_ptr_q] == 4'b0101) || (f_cmd[rd_ptr_q] == 4'b0110) ||
                        (f_cmd[rd_ptr_q] == 4'b1001) || (f_cmd[rd_ptr_q] == 4'b1010);
    assign head_sll   = (f_cmd[rd_ptr_q] == 4'b0101) || (f_cmd[rd_ptr_q] == 4'b1001);
    assign head_amt   = head_valid ? f_amt[rd_ptr_q] : 5'd0;
    assign step       = (rem_q < 5'd4) ? rem_q : 5'd4;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rem_d   = rem_q;
        sll_d   = sll_q;
        cmd_d   = cmd_q;
        tag_d   = tag_q;
        reg_d   = reg_q;
        fb_d    = fb_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    w_d   = {32'b0, head_valid ? f_d1[rd_ptr_q] : 32'b0};
                    rem_d = head_amt;
                    sll_d = head_sll;
                    cmd_d = f_cmd[rd_ptr_q];
                    tag_d = f_tag[rd_ptr_q];
                    reg_d = f_reg[rd_ptr_q];
                    fb_d  = f_fb[rd_ptr_q];
                    if (head_amt != 5'd0) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StShift: begin
                w_d   = sll_q ? (w_q << step) : (w_q >> step);
                rem_d = rem_q - step;
                if (rem_d == 5'd0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result beat registers are loaded only on the edge entering DONE, cleared otherwise
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            w_q       <= '0;
            rem_q     <= '0;
            sll_q     <= 1'b0;
            cmd_q     <= '0;
            tag_q     <= '0;
            reg_q     <= '0;
            fb_q      <= '0;
            out_cmd_q <= '0;
            out_tag_q <= '0;
            out_res_q <= '0;
            out_reg_q <= '0;
            out_fb_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rem_q   <= rem_d;
            sll_q   <= sll_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            reg_q   <= reg_d;
            fb_q    <= fb_d;
            if (done_d) begin
                out_cmd_q <= cmd_d;
                out_tag_q <= tag_d;
                out_res_q <= w_d;
                out_reg_q <= reg_d;
                out_fb_q  <= fb_d;
            end else begin
                out_cmd_q <= '0;
                out_tag_q <= '0;
                out_res_q <= '0;
                out_reg_q <= '0;
                out_fb_q  <= '0;
            end
        end
    end

    assign shift_out_cmd       = out_cmd_q;
    assign shift_tag           = out_tag_q;
    assign shift_result        = out_res_q;
    assign shift_result_reg    = out_reg_q;
    assign shift_follow_branch = out_fb_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Randomised bench for shift_exec_stage against a queue-based cycle model.
// The model tracks remaining busy cycles per command and computes results arithmetically.
module tb_shift_exec_stage;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        in_vld;
    logic        in_rdy;
    logic [0:3]  in_cmd;
    logic [0:3]  in_tag;
    logic [0:31] in_data1;
    logic [0:31] in_data2;
    logic [0:4]  in_result_reg;
    logic [0:4]  in_follow_branch;
    logic [0:3]  shift_out_cmd;
    logic [0:3]  shift_tag;
    logic [0:63] shift_result;
    logic [0:4]  shift_result_reg;
    logic [0:4]  shift_follow_branch;
    logic        busy;

    shift_exec_stage dut (
        .c_clk              (c_clk),
        .reset              (reset),
        .in_vld             (in_vld),
        .in_rdy             (in_rdy),
        .in_cmd             (in_cmd),
        .in_tag             (in_tag),
        .in_data1           (in_data1),
        .in_data2           (in_data2),
        .in_result_reg      (in_result_reg),
        .in_follow_branch   (in_follow_branch),
        .shift_out_cmd      (shift_out_cmd),
        .shift_tag          (shift_tag),
        .shift_result       (shift_result),
        .shift_result_reg   (shift_result_reg),
        .shift_follow_branch(shift_follow_branch),
        .busy               (busy)
    );

    always #5 c_clk = !c_clk;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rreg;
        logic [4:0]  fb;
    } cmd_t;

    cmd_t fifo[$];
    cmd_t cur;
    int   remaining;
    int   checks = 0;
    int   failures = 0;

    function automatic bit is_valid(logic [3:0] c);
        return c == 4'b0101 || c == 4'b0110 || c == 4'b1001 || c == 4'b1010;
    endfunction

    function automatic int amt_of(cmd_t c);
        return is_valid(c.cmd) ? int'(c.d2 % 32) : 0;
    endfunction

    function automatic logic [63:0] result_of(cmd_t c);
        logic [63:0] x;
        x = {32'b0, c.d1};
        if (!is_valid(c.cmd)) return 64'd0;
        if (c.cmd == 4'b0101 || c.cmd == 4'b1001) return x << amt_of(c);
        return x >> amt_of(c);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        fifo.delete();
        remaining = 0;
    endtask

    // Advance the model by one rising edge using the inputs held across that edge.
    task automatic model_edge();
        bit   can_push;
        cmd_t c;
        if (reset) begin
            model_clear();
            return;
        end
        can_push = in_vld && (fifo.size() < 2);
        if (remaining > 0) begin
            remaining--;
        end else if (fifo.size() > 0) begin
            cur = fifo.pop_front();
            remaining = (amt_of(cur) + 3) / 4 + 1;
        end
        if (can_push) begin
            c.cmd  = in_cmd;
            c.tag  = in_tag;
            c.d1   = in_data1;
            c.d2   = in_data2;
            c.rreg = in_result_reg;
            c.fb   = in_follow_branch;
            fifo.push_back(c);
        end
    endtask

    task automatic check_outputs();
        bit beat;
        beat = (remaining == 1);
        check_eq("in_rdy", 64'(in_rdy), 64'(!reset && fifo.size() < 2));
        check_eq("busy", 64'(busy), 64'(remaining > 0 || fifo.size() > 0));
        check_eq("out_cmd", 64'(shift_out_cmd), beat ? 64'(cur.cmd) : 64'd0);
        check_eq("tag", 64'(shift_tag), beat ? 64'(cur.tag) : 64'd0);
        check_eq("result", shift_result, beat ? result_of(cur) : 64'd0);
        check_eq("result_reg", 64'(shift_result_reg), beat ? 64'(cur.rreg) : 64'd0);
        check_eq("follow_branch", 64'(shift_follow_branch), beat ? 64'(cur.fb) : 64'd0);
    endtask

    // Called shortly after a rising edge: apply inputs, check at falling edge, step the model.
    task automatic cycle(input bit rst, input bit vld, input logic [3:0] cmd,
                         input logic [3:0] tag, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rreg, input logic [4:0] fb);
        reset            = rst;
        in_vld           = vld;
        in_cmd           = cmd;
        in_tag           = tag;
        in_data1         = d1;
        in_data2         = d2;
        in_result_reg    = rreg;
        in_follow_branch = fb;
        if (rst) model_clear();
        @(negedge c_clk);
        check_outputs();
        @(posedge c_clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [3:0] cmd, input logic [3:0] tag, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [4:0] rreg, input logic [4:0] fb);
        cycle(1'b0, 1'b1, cmd, tag, d1, d2, rreg, fb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 5'h0, 5'h0);
    endtask

    logic [3:0] valid_cmds [4];

    initial begin
        valid_cmds[0] = 4'b0101;
        valid_cmds[1] = 4'b0110;
        valid_cmds[2] = 4'b1001;
        valid_cmds[3] = 4'b1010;
        model_clear();
        cur = '0;
        #1;
        cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 5'h0, 5'h0);
        cycle(1'b1, 1'b1, 4'b0101, 4'h3, 32'h1, 32'h1, 5'h1, 5'h1);
        idle(2);

        send(4'b0101, 4'b0110, 32'h8000_0001, 32'h0, 5'b10011, 5'b00000);
        idle(3);
        send(4'b1001, 4'b0001, 32'h8000_0001, 32'h4, 5'b00001, 5'b00000);
        idle(4);
        send(4'b1010, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00010, 5'b10101);
        idle(11);

        // Backpressure: three commands back to back behind a long shift
        send(4'b0110, 4'b1000, 32'hDEAD_BEEF, 32'd31, 5'b10001, 5'b00011);
        send(4'b0101, 4'b1001, 32'h1234_5678, 32'd7, 5'b10010, 5'b00100);
        send(4'b1001, 4'b1010, 32'hCAFE_F00D, 32'd13, 5'b10100, 5'b00101);
        send(4'b1010, 4'b1011, 32'h0F0F_0F0F, 32'd2, 5'b11000, 5'b00110);
        idle(30);

        // Reset mid-shift with a second command buffered
        send(4'b0101, 4'b1110, 32'hAAAA_5555, 32'd20, 5'b11111, 5'b11111);
        send(4'b0110, 4'b1101, 32'h5555_AAAA, 32'd3, 5'b11110, 5'b11110);
        idle(1);
        cycle(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 5'h0, 5'h0);
        send(4'b0101, 4'b0111, 32'h0000_00FF, 32'h0, 5'b10111, 5'b01010);
        idle(3);

        send(4'b0011, 4'b1100, 32'h1234_5678, 32'd8, 5'b11001, 5'b10001);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            logic [3:0]  c;
            logic [31:0] d2;
            c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : valid_cmds[$urandom_range(0, 3)];
            d2 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 9));
            cycle($urandom_range(0, 80) == 0, $urandom_range(0, 2) != 0, c, 4'($urandom),
                  $urandom, d2, 5'($urandom), 5'($urandom));
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
